// File: rtl/reg_file_sb_pkg.sv
// Shared types and sizing for the register file / scoreboard slice.
package reg_file_sb_pkg;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int RW    = $clog2(NREGS);
    localparam int CNT_W = 2;

    typedef logic [CNT_W-1:0] SbCnt;

    localparam SbCnt CNT_MAX = '1;

    // Writeback bundle as produced by the writeback stage.
    typedef struct packed {
        logic            wback;
        logic [RW-1:0]   wreg;
        logic [XLEN-1:0] wdata;
        logic            pcsel;
    } Signals;

endpackage

// File: rtl/reg_file_sb_sb_counter.sv
// One per-register pending-write counter: saturating up/down with a clear.
module sb_counter
    import reg_file_sb_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             inc_i,
    input  logic             dec_i,
    output logic [CNT_W-1:0] cnt_o
);

    SbCnt cnt_q, cnt_d;
    logic dec_eff;

    // A retire against an empty counter is an underflow; it never decrements.
    assign dec_eff = dec_i && (cnt_q != '0);

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = '0;
        else if (inc_i && !dec_eff && cnt_q != CNT_MAX)
            cnt_d = cnt_q + SbCnt'(1);
        else if (dec_eff && !inc_i)
            cnt_d = cnt_q - SbCnt'(1);
    end

    always_ff @(posedge clk) begin
        if (rst)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/reg_file_sb.sv
// Architectural register file with same-cycle write bypass and a
// per-register pending-write scoreboard that produces the issue stall.
module reg_file_sb
    import reg_file_sb_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  Signals          i_signals,
    input  logic            issue_valid,
    input  logic [RW-1:0]   rs1,
    input  logic [RW-1:0]   rs2,
    input  logic            use_rs1,
    input  logic            use_rs2,
    input  logic [RW-1:0]   rd,
    input  logic            rd_en,
    output logic [XLEN-1:0] rdata1,
    output logic [XLEN-1:0] rdata2,
    output logic            stall,
    output logic            sb_err
);

    logic [XLEN-1:0]             regs_q [NREGS];
    logic [NREGS-1:0][CNT_W-1:0] cnt;
    logic                        sb_err_q, sb_err_d;
    logic                        wr_en;
    logic                        busy1, busy2, waw_full, accept;

    assign wr_en = i_signals.wback && (i_signals.wreg != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++)
                regs_q[i] <= '0;
        end else if (wr_en) begin
            regs_q[i_signals.wreg] <= i_signals.wdata;
        end
    end

    always_comb begin
        rdata1 = regs_q[rs1];
        if (rs1 == '0)
            rdata1 = '0;
        else if (i_signals.wback && i_signals.wreg == rs1)
            rdata1 = i_signals.wdata;
    end

    always_comb begin
        rdata2 = regs_q[rs2];
        if (rs2 == '0)
            rdata2 = '0;
        else if (i_signals.wback && i_signals.wreg == rs2)
            rdata2 = i_signals.wdata;
    end

    // The last pending write retiring this cycle is bypassed, so it is not busy.
    always_comb begin
        busy1 = (cnt[rs1] != '0) &&
                !(i_signals.wback && i_signals.wreg == rs1 && cnt[rs1] == SbCnt'(1));
        busy2 = (cnt[rs2] != '0) &&
                !(i_signals.wback && i_signals.wreg == rs2 && cnt[rs2] == SbCnt'(1));
        waw_full = rd_en && (rd != '0) && (cnt[rd] == CNT_MAX) &&
                   !(i_signals.wback && i_signals.wreg == rd);
    end

    assign stall  = issue_valid && ((use_rs1 && busy1) || (use_rs2 && busy2) || waw_full);
    assign accept = issue_valid && !stall && !i_signals.pcsel;

    assign cnt[0] = '0;

    for (genvar r = 1; r < NREGS; r++) begin : g_cnt
        sb_counter u_cnt (
            .clk   (clk),
            .rst   (rst),
            .clr_i (i_signals.pcsel),
            .inc_i (accept && rd_en && rd == RW'(r)),
            .dec_i (i_signals.wback && i_signals.wreg == RW'(r)),
            .cnt_o (cnt[r])
        );
    end

    always_comb begin
        sb_err_d = sb_err_q;
        if (wr_en && cnt[i_signals.wreg] == '0)
            sb_err_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst)
            sb_err_q <= 1'b0;
        else
            sb_err_q <= sb_err_d;
    end

    assign sb_err = sb_err_q;

endmodule

// File: tb/tb_reg_file_sb.sv
// Randomised plus directed check of reg_file_sb against a behavioural model.
module tb_reg_file_sb;
    import reg_file_sb_pkg::*;

    logic            clk = 1'b0;
    logic            rst;
    Signals          sig;
    logic            issue_valid, use_rs1, use_rs2, rd_en;
    logic [RW-1:0]   rs1, rs2, rd;
    logic [XLEN-1:0] rdata1, rdata2;
    logic            stall, sb_err;

    int tests = 0;
    int fails = 0;

    logic [XLEN-1:0] mregs [NREGS];
    int              mcnt  [NREGS];
    bit              merr;
    bit              mvalid = 1'b0;
    int              cmax;

    always #5 clk = ~clk;

    reg_file_sb dut (
        .clk         (clk),
        .rst         (rst),
        .i_signals   (sig),
        .issue_valid (issue_valid),
        .rs1         (rs1),
        .rs2         (rs2),
        .use_rs1     (use_rs1),
        .use_rs2     (use_rs2),
        .rd          (rd),
        .rd_en       (rd_en),
        .rdata1      (rdata1),
        .rdata2      (rdata2),
        .stall       (stall),
        .sb_err      (sb_err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] m_read(input int r);
        if (r == 0) return 32'h0;
        if (sig.wback && int'(sig.wreg) == r) return sig.wdata;
        return mregs[r];
    endfunction

    function automatic bit m_busy(input int r);
        return mcnt[r] > 0 && !(sig.wback && int'(sig.wreg) == r && mcnt[r] == 1);
    endfunction

    function automatic bit m_stall();
        bit full;
        full = rd_en && rd != 0 && mcnt[rd] == cmax && !(sig.wback && sig.wreg == rd);
        return issue_valid && ((use_rs1 && m_busy(int'(rs1))) ||
                               (use_rs2 && m_busy(int'(rs2))) || full);
    endfunction

    task automatic m_update();
        bit acc, dec;
        int w;
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin mregs[i] = '0; mcnt[i] = 0; end
            merr = 1'b0;
            mvalid = 1'b1;
            return;
        end
        acc = issue_valid && !m_stall() && !sig.pcsel;
        w = int'(sig.wreg);
        dec = sig.wback && w != 0 && mcnt[w] > 0;
        if (sig.wback && w != 0) begin
            mregs[w] = sig.wdata;
            if (mcnt[w] == 0) merr = 1'b1;
        end
        if (sig.pcsel) begin
            for (int i = 0; i < NREGS; i++) mcnt[i] = 0;
        end else begin
            if (acc && rd_en && rd != 0) mcnt[rd]++;
            if (dec) mcnt[w]--;
        end
    endtask

    task automatic tick();
        if (mvalid) begin
            chk("rdata1", rdata1, m_read(int'(rs1)));
            chk("rdata2", rdata2, m_read(int'(rs2)));
            chk("stall", 32'(stall), 32'(m_stall()));
            chk("sb_err", 32'(sb_err), 32'(merr));
        end
        @(posedge clk);
        m_update();
        @(negedge clk);
    endtask

    task automatic drive(input bit r, input bit iv, input int s1, input bit u1, input int s2,
                         input bit u2, input int d, input bit de, input bit wb, input int wr,
                         input logic [31:0] wd, input bit pc);
        rst = r; issue_valid = iv;
        rs1 = RW'(s1); use_rs1 = u1; rs2 = RW'(s2); use_rs2 = u2;
        rd = RW'(d); rd_en = de;
        sig.wback = wb; sig.wreg = RW'(wr); sig.wdata = wd; sig.pcsel = pc;
        #1;
    endtask

    task automatic idle(input int s1, input int s2);
        drive(0, 0, s1, 0, s2, 0, 0, 0, 0, 0, 32'h0, 0);
    endtask

    initial begin
        int pick;
        cmax = (1 << CNT_W) - 1;
        @(negedge clk);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 1, 3, 32'h55, 0);
        tick();

        // Reset state
        idle(5, 6);
        chk("rst_rdata1", rdata1, 32'h0);
        chk("rst_rdata2", rdata2, 32'h0);
        chk("rst_stall", 32'(stall), 32'h0);
        chk("rst_sb_err", 32'(sb_err), 32'h0);
        chk("rst_write_dropped", 32'(dut.regs_q[3]), 32'h0);
        tick();

        // RAW on x5 released by its own writeback
        drive(0, 1, 0, 0, 0, 0, 5, 1, 0, 0, 32'h0, 0); tick();
        idle(0, 0); tick();
        drive(0, 1, 5, 1, 0, 0, 0, 0, 0, 0, 32'h0, 0);
        chk("raw_stall", 32'(stall), 32'h1);
        tick();
        drive(0, 1, 5, 1, 0, 0, 0, 0, 1, 5, 32'hDEADBEEF, 0);
        chk("raw_release_stall", 32'(stall), 32'h0);
        chk("raw_bypass", rdata1, 32'hDEADBEEF);
        tick();
        idle(5, 0);
        chk("raw_array", rdata1, 32'hDEADBEEF);
        tick();

        // WAW saturation on x7
        repeat (3) begin drive(0, 1, 0, 0, 0, 0, 7, 1, 0, 0, 32'h0, 0); tick(); end
        drive(0, 1, 0, 0, 0, 0, 7, 1, 0, 0, 32'h0, 0);
        chk("waw_full_stall", 32'(stall), 32'h1);
        tick();
        drive(0, 1, 0, 0, 0, 0, 7, 1, 1, 7, 32'h77, 0);
        chk("waw_wb_accept", 32'(stall), 32'h0);
        tick();
        drive(0, 1, 0, 0, 0, 0, 7, 1, 0, 0, 32'h0, 0);
        chk("waw_still_full", 32'(stall), 32'h1);
        tick();
        repeat (3) begin drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 7, 32'h70, 0); tick(); end

        // x0 is never written
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h1234, 0);
        chk("x0_bypass", rdata1, 32'h0);
        tick();
        idle(0, 0);
        chk("x0_read", rdata1, 32'h0);
        chk("x0_no_err", 32'(sb_err), 32'h0);
        tick();

        // Flush clears all pending state; its writeback still commits
        drive(0, 1, 0, 0, 0, 0, 3, 1, 0, 0, 32'h0, 0); tick();
        drive(0, 1, 0, 0, 0, 0, 4, 1, 0, 0, 32'h0, 0); tick();
        drive(0, 1, 0, 0, 0, 0, 9, 1, 1, 2, 32'hAA, 1); tick();
        drive(0, 1, 3, 1, 9, 1, 0, 0, 0, 0, 32'h0, 0);
        chk("flush_stall", 32'(stall), 32'h0);
        tick();
        drive(0, 1, 2, 1, 4, 1, 0, 0, 0, 0, 32'h0, 0);
        chk("flush_wb_commit", rdata1, 32'hAA);
        chk("flush_x4_free", 32'(stall), 32'h0);
        tick();

        // Underflow sets sticky error
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 8, 32'h88, 0); tick();
        idle(8, 0);
        chk("uf_write", rdata1, 32'h88);
        chk("uf_err", 32'(sb_err), 32'h1);
        tick();
        drive(0, 1, 0, 0, 0, 0, 10, 1, 0, 0, 32'h0, 0); tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 10, 32'h10, 0); tick();
        idle(0, 0);
        chk("uf_err_sticky", 32'(sb_err), 32'h1);
        tick();

        // Randomised traffic
        for (int n = 0; n < 3000; n++) begin
            pick = $urandom_range(1, NREGS - 1);
            for (int k = 0; k < 8 && mcnt[pick] == 0; k++) pick = $urandom_range(1, NREGS - 1);
            if ($urandom_range(0, 3) == 0) pick = $urandom_range(0, NREGS - 1);
            drive($urandom_range(0, 199) == 0, $urandom_range(0, 9) < 6,
                  $urandom_range(0, NREGS - 1), $urandom_range(0, 1),
                  $urandom_range(0, NREGS - 1), $urandom_range(0, 1),
                  $urandom_range(0, 7), $urandom_range(0, 3) != 0,
                  $urandom_range(0, 9) < 5, pick, $urandom(), $urandom_range(0, 29) == 0);
            tick();
        end

        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0); tick();
        idle(8, 7);
        chk("final_err_clear", 32'(sb_err), 32'h0);
        chk("final_regs_clear", rdata1 | rdata2, 32'h0);
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
